// File: rtl/mem_port_arbiter_if.sv
// Bundle of request, response and memory-side signals for mem_port_arbiter.
// The arbiter connects through the slave modport; the pipeline/memory side uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_rdata, if_ack, ls_rdata, ls_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_rdata, if_ack, ls_rdata, ls_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between IF and MEM stages, one access at a time.
// Define MEM_ARB_FAIRNESS_EN to let a starved fetch win a tie after STARVE_MAX load/store grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;   // 1 = load/store owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;

  logic idle;
  logic if_priority;
  logic grant_ls;
  logic grant_if;

  assign idle     = (state_q == S_IDLE);
  assign grant_ls = idle && bus.ls_req && !if_priority;
  assign grant_if = idle && bus.if_req && !grant_ls;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_q, starve_d;

  assign if_priority = bus.if_req && (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = 3'd0;
    end else if (grant_ls && bus.if_req) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign if_priority = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_cnt_d  = lat_cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    if_ack_d   = 1'b0;
    ls_ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_ls || grant_if) begin
          owner_d = grant_ls;
          we_d    = grant_ls && bus.ls_we;
          addr_d  = grant_ls ? bus.ls_addr : bus.if_addr;
          wdata_d = grant_ls ? bus.ls_wdata : wdata_q;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Count of 1 marks the cycle the memory presents valid read data.
        if (lat_cnt_q == 4'd1) begin
          if (owner_q) begin
            if (!we_q) begin
              ls_rdata_d = bus.mem_rdata;
            end
            ls_ack_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt_q  <= 4'd0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_cnt_q  <= lat_cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
    end
  end

  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = (state_q == S_ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.busy      = !idle;
  assign bus.stall_if  = bus.if_req && !if_ack_q;
  assign bus.stall_mem = bus.ls_req && !ls_ack_q;

endmodule
